mem_req_arbiter: RTL and testbench

// - Shares the single byte-stream command port of mem_top (VALID_IN/DATA_IN/READY_IN) among NUM_REQ crypto requesters.
// - Uses round-robin grant. A grant is held for one whole transaction: the command bytes up to and including the LAST byte, then the ACK.
// - Routes the mem_top ACK back to the owning requester as a one-cycle pulse, then releases the port.
// - Sits between the requester bus logic and mem_top. One transaction is outstanding at a time.

---
 rtl/mem_req_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing the mem_top byte-stream command port among NUM_REQ requesters.
// Optional ACK watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_req_arbiter #(
   parameter int NUM_REQ        = 3,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [NUM_REQ-1:0]     req_ack,
   output logic                   mem_valid_in,
   output logic [7:0]             mem_data_in,
   input  logic                   mem_ready_in,
   input  logic                   mem_ack_valid,
   output logic                   mem_ack_ready,
   input  logic [1:0]             mem_source_id,
   output logic [1:0]             ack_source_id,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   busy,
   output logic                   timeout_err
);

   localparam int IW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
   localparam int CW = IW + 1;

   if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
      $error("mem_req_arbiter: NUM_REQ must be 2..4");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("mem_req_arbiter: TIMEOUT_CYCLES must be at least 2");
   end

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      STREAM   = 2'd1,
      WAIT_ACK = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   state_t               state_r;
   logic [IW-1:0]        rr_ptr_r;
   logic [IW-1:0]        gidx_r;
   logic [NUM_REQ-1:0]   grant_r;
   logic [NUM_REQ-1:0]   req_ack_r;
   logic [1:0]           ack_source_id_r;
   logic                 busy_r;
   logic                 mem_ack_ready_r;

   logic [IW-1:0]        pick_idx_s;
   logic                 pick_any_s;
   logic [CW-1:0]        sum_s;
   logic [CW-1:0]        cand_s;
   logic [IW-1:0]        next_ptr_s;
   logic                 mem_valid_s;
   logic [7:0]           mem_data_s;
   logic [NUM_REQ-1:0]   req_ready_s;
   logic                 xfer_s;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]        wait_cnt_r;
   logic                 timeout_err_r;
`endif

   // Round-robin search: scan from lowest to highest priority so the first valid from rr_ptr wins.
   always_comb begin
      pick_idx_s = {IW{1'b0}};
      pick_any_s = 1'b0;
      sum_s      = {CW{1'b0}};
      cand_s     = {CW{1'b0}};
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         sum_s      = {1'b0, rr_ptr_r} + CW'(i);
         cand_s     = (sum_s >= CW'(NUM_REQ)) ? (sum_s - CW'(NUM_REQ)) : sum_s;
         pick_idx_s = req_valid[cand_s[IW-1:0]] ? cand_s[IW-1:0] : pick_idx_s;
         pick_any_s = pick_any_s | req_valid[cand_s[IW-1:0]];
      end
   end

   // Pointer to the requester after the current owner, wrapping to 0.
   always_comb begin
      if (gidx_r == IW'(NUM_REQ - 1)) begin
         next_ptr_s = {IW{1'b0}};
      end else begin
         next_ptr_s = gidx_r + IW'(1);
      end
   end

   // Zero-latency byte path from the granted requester to mem_top.
   always_comb begin
      mem_valid_s = 1'b0;
      mem_data_s  = 8'h00;
      req_ready_s = {NUM_REQ{1'b0}};
      if (state_r == STREAM) begin
         mem_valid_s = req_valid[gidx_r];
         mem_data_s  = req_data[{gidx_r, 3'b000} +: 8];
         req_ready_s = mem_ready_in ? grant_r : {NUM_REQ{1'b0}};
      end else begin
         mem_valid_s = 1'b0;
         mem_data_s  = 8'h00;
         req_ready_s = {NUM_REQ{1'b0}};
      end
   end

   assign xfer_s = mem_valid_s & mem_ready_in;

   // Transaction FSM with all control outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r         <= IDLE;
         rr_ptr_r        <= {IW{1'b0}};
         gidx_r          <= {IW{1'b0}};
         grant_r         <= {NUM_REQ{1'b0}};
         req_ack_r       <= {NUM_REQ{1'b0}};
         ack_source_id_r <= 2'b00;
         busy_r          <= 1'b0;
         mem_ack_ready_r <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         wait_cnt_r      <= {TW{1'b0}};
         timeout_err_r   <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (pick_any_s) begin
                  gidx_r  <= pick_idx_s;
                  grant_r <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
                  busy_r  <= 1'b1;
                  state_r <= STREAM;
               end else begin
                  state_r <= IDLE;
               end
            end
            STREAM: begin
               if (xfer_s && req_last[gidx_r]) begin
                  mem_ack_ready_r <= 1'b1;
                  state_r         <= WAIT_ACK;
`ifdef MEM_ARB_TIMEOUT_EN
                  wait_cnt_r      <= {TW{1'b0}};
`endif
               end else begin
                  state_r <= STREAM;
               end
            end
            WAIT_ACK: begin
               if (mem_ack_valid) begin
                  ack_source_id_r <= mem_source_id;
                  req_ack_r       <= grant_r;
                  mem_ack_ready_r <= 1'b0;
                  state_r         <= RELEASE;
`ifdef MEM_ARB_TIMEOUT_EN
               end else if (wait_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
                  // Watchdog expiry completes the transaction without a real ACK.
                  timeout_err_r   <= 1'b1;
                  req_ack_r       <= grant_r;
                  mem_ack_ready_r <= 1'b0;
                  state_r         <= RELEASE;
               end else begin
                  wait_cnt_r <= wait_cnt_r + TW'(1);
               end
`else
               end else begin
                  state_r <= WAIT_ACK;
               end
`endif
            end
            RELEASE: begin
               req_ack_r <= {NUM_REQ{1'b0}};
               grant_r   <= {NUM_REQ{1'b0}};
               busy_r    <= 1'b0;
               rr_ptr_r  <= next_ptr_s;
               state_r   <= IDLE;
            end
            default: begin
               req_ack_r       <= {NUM_REQ{1'b0}};
               grant_r         <= {NUM_REQ{1'b0}};
               busy_r          <= 1'b0;
               mem_ack_ready_r <= 1'b0;
               state_r         <= IDLE;
            end
         endcase
      end
   end

   assign req_ready     = req_ready_s;
   assign req_ack       = req_ack_r;
   assign mem_valid_in  = mem_valid_s;
   assign mem_data_in   = mem_data_s;
   assign mem_ack_ready = mem_ack_ready_r;
   assign ack_source_id = ack_source_id_r;
   assign grant         = grant_r;
   assign busy          = busy_r;
`ifdef MEM_ARB_TIMEOUT_EN
   assign timeout_err   = timeout_err_r;
`else
   assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_mem_req_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req_valid;
   logic [23:0] req_data;
   logic [2:0]  req_last;
   logic [2:0]  req_ready;
   logic [2:0]  req_ack;
   logic        mem_valid_in;
   logic [7:0]  mem_data_in;
   logic        mem_ready_in;
   logic        mem_ack_valid;
   logic        mem_ack_ready;
   logic [1:0]  mem_source_id;
   logic [1:0]  ack_source_id;
   logic [2:0]  grant;
   logic        busy;
   logic        timeout_err;

   int checks = 0;
   int errors = 0;

   mem_req_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .req_ack(req_ack),
      .mem_valid_in(mem_valid_in), .mem_data_in(mem_data_in), .mem_ready_in(mem_ready_in),
      .mem_ack_valid(mem_ack_valid), .mem_ack_ready(mem_ack_ready),
      .mem_source_id(mem_source_id), .ack_source_id(ack_source_id),
      .grant(grant), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  valid;
      logic [23:0] data;
      logic [2:0]  last;
      logic        rdy;
      logic        ackv;
      logic [1:0]  id;
      logic [2:0]  e_grant;
      logic        e_mval;
      logic [7:0]  e_mdata;
      logic [2:0]  e_rdy;
      logic [2:0]  e_ack;
      logic [1:0]  e_src;
      logic        e_busy;
      logic        e_ackrdy;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [2:0] act, input int g, input bit second);
      req_valid = act;
      for (int i = 0; i < 3; i++) begin
         req_data[8*i +: 8] = (i == g && second) ? 8'(16*i + 1) : 8'(16*i);
         req_last[i]        = (i == g && second);
      end
   endtask

   // Two-byte transaction; act lists every requester holding valid, g is the expected owner.
   task automatic txn(input logic [2:0] act, input int g, input logic [1:0] id);
      logic [2:0] gm;
      gm = 3'b001 << g;
      mem_ready_in = 1'b1;
      cyc(); set_req(act, g, 1'b0); #1;
      chk("txn_idle_grant", grant, 3'b000);
      cyc(); set_req(act, g, 1'b0); #1;
      chk("txn_grant", grant, gm);
      chk("txn_byte0", mem_data_in, 8'(16*g));
      chk("txn_mvalid", mem_valid_in, 1'b1);
      cyc(); set_req(act, g, 1'b1); #1;
      chk("txn_byte1", mem_data_in, 8'(16*g + 1));
      chk("txn_ready", req_ready, gm);
      cyc(); set_req(act & ~gm, g, 1'b0); mem_ack_valid = 1'b1; mem_source_id = id; #1;
      chk("txn_ackrdy", mem_ack_ready, 1'b1);
      chk("txn_no_early_ack", req_ack, 3'b000);
      cyc(); mem_ack_valid = 1'b0; #1;
      chk("txn_ack", req_ack, gm);
      chk("txn_ack_src", ack_source_id, id);
   endtask

   logic [7:0] bt  [3];
   logic       pat [5];
   int         k;
   int         nx;

   initial begin
      rst = 1'b1; req_valid = 3'b000; req_data = 24'h0; req_last = 3'b000;
      mem_ready_in = 1'b0; mem_ack_valid = 1'b0; mem_source_id = 2'd0;

      // valid, data, last, rdy, ackv, id | grant, mval, mdata, rdy, ack, src, busy, ackrdy
      tbl[0]  = '{3'b010, 24'h000300, 3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 8'h00, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0};
      tbl[1]  = '{3'b010, 24'h000300, 3'b000, 1'b1, 1'b0, 2'd0, 3'b010, 1'b1, 8'h03, 3'b010, 3'b000, 2'd0, 1'b1, 1'b0};
      tbl[2]  = '{3'b010, 24'h000000, 3'b000, 1'b1, 1'b0, 2'd0, 3'b010, 1'b1, 8'h00, 3'b010, 3'b000, 2'd0, 1'b1, 1'b0};
      tbl[3]  = '{3'b010, 24'h001000, 3'b000, 1'b1, 1'b0, 2'd0, 3'b010, 1'b1, 8'h10, 3'b010, 3'b000, 2'd0, 1'b1, 1'b0};
      tbl[4]  = '{3'b010, 24'h000000, 3'b010, 1'b1, 1'b0, 2'd0, 3'b010, 1'b1, 8'h00, 3'b010, 3'b000, 2'd0, 1'b1, 1'b0};
      tbl[5]  = '{3'b000, 24'h000000, 3'b000, 1'b1, 1'b1, 2'd2, 3'b010, 1'b0, 8'h00, 3'b000, 3'b000, 2'd0, 1'b1, 1'b1};
      tbl[6]  = '{3'b000, 24'h000000, 3'b000, 1'b1, 1'b0, 2'd0, 3'b010, 1'b0, 8'h00, 3'b000, 3'b010, 2'd2, 1'b1, 1'b0};
      tbl[7]  = '{3'b000, 24'h000000, 3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 8'h00, 3'b000, 3'b000, 2'd2, 1'b0, 1'b0};
      tbl[8]  = '{3'b001, 24'h000011, 3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 8'h00, 3'b000, 3'b000, 2'd2, 1'b0, 1'b0};
      tbl[9]  = '{3'b101, 24'hAA0011, 3'b000, 1'b1, 1'b0, 2'd0, 3'b001, 1'b1, 8'h11, 3'b001, 3'b000, 2'd2, 1'b1, 1'b0};
      tbl[10] = '{3'b101, 24'hAA0022, 3'b001, 1'b1, 1'b0, 2'd0, 3'b001, 1'b1, 8'h22, 3'b001, 3'b000, 2'd2, 1'b1, 1'b0};
      tbl[11] = '{3'b100, 24'hAA0000, 3'b000, 1'b1, 1'b1, 2'd1, 3'b001, 1'b0, 8'h00, 3'b000, 3'b000, 2'd2, 1'b1, 1'b1};
      tbl[12] = '{3'b100, 24'hAA0000, 3'b000, 1'b1, 1'b0, 2'd0, 3'b001, 1'b0, 8'h00, 3'b000, 3'b001, 2'd1, 1'b1, 1'b0};
      tbl[13] = '{3'b100, 24'hAA0000, 3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 8'h00, 3'b000, 3'b000, 2'd1, 1'b0, 1'b0};
      tbl[14] = '{3'b100, 24'hAA0000, 3'b100, 1'b1, 1'b0, 2'd0, 3'b100, 1'b1, 8'hAA, 3'b100, 3'b000, 2'd1, 1'b1, 1'b0};
      tbl[15] = '{3'b000, 24'h000000, 3'b000, 1'b1, 1'b1, 2'd3, 3'b100, 1'b0, 8'h00, 3'b000, 3'b000, 2'd1, 1'b1, 1'b1};
      tbl[16] = '{3'b000, 24'h000000, 3'b000, 1'b1, 1'b0, 2'd0, 3'b100, 1'b0, 8'h00, 3'b000, 3'b100, 2'd3, 1'b1, 1'b0};
      tbl[17] = '{3'b000, 24'h000000, 3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 8'h00, 3'b000, 3'b000, 2'd3, 1'b0, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_grant", grant, 3'b000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ack", req_ack, 3'b000);
      chk("rst_src", ack_source_id, 2'd0);
      chk("rst_ackrdy", mem_ack_ready, 1'b0);
      chk("rst_mvalid", mem_valid_in, 1'b0);
      chk("rst_timeout", timeout_err, 1'b0);
      rst = 1'b0;

      // Single requester packet, then isolation of a waiting requester and wrap of the pointer.
      for (int r = 0; r < 18; r++) begin
         cyc();
         req_valid = tbl[r].valid; req_data = tbl[r].data; req_last = tbl[r].last;
         mem_ready_in = tbl[r].rdy; mem_ack_valid = tbl[r].ackv; mem_source_id = tbl[r].id;
         #1;
         chk($sformatf("v%0d_grant", r), grant, tbl[r].e_grant);
         chk($sformatf("v%0d_mvalid", r), mem_valid_in, tbl[r].e_mval);
         chk($sformatf("v%0d_mdata", r), mem_data_in, tbl[r].e_mdata);
         chk($sformatf("v%0d_ready", r), req_ready, tbl[r].e_rdy);
         chk($sformatf("v%0d_ack", r), req_ack, tbl[r].e_ack);
         chk($sformatf("v%0d_src", r), ack_source_id, tbl[r].e_src);
         chk($sformatf("v%0d_busy", r), busy, tbl[r].e_busy);
         chk($sformatf("v%0d_ackrdy", r), mem_ack_ready, tbl[r].e_ackrdy);
      end

      // Contention: 0,1,2; req 0 alone moves the pointer to 1; then 1,2,0.
      txn(3'b111, 0, 2'd0);
      txn(3'b111, 1, 2'd1);
      txn(3'b111, 2, 2'd2);
      txn(3'b001, 0, 2'd3);
      txn(3'b111, 1, 2'd1);
      txn(3'b111, 2, 2'd2);
      txn(3'b111, 0, 2'd0);

      // Backpressure on a 3-byte packet from requester 1.
      bt[0] = 8'h51; bt[1] = 8'h52; bt[2] = 8'h53;
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;
      cyc(); req_valid = 3'b010; req_data = {8'h00, bt[0], 8'h00}; req_last = 3'b000; mem_ready_in = 1'b1; #1;
      chk("bp_idle", grant, 3'b000);
      k = 0; nx = 0;
      for (int c = 0; c < 5; c++) begin
         cyc();
         req_data = {8'h00, bt[k], 8'h00};
         req_last = (k == 2) ? 3'b010 : 3'b000;
         mem_ready_in = pat[c];
         #1;
         chk($sformatf("bp%0d_data", c), mem_data_in, bt[k]);
         chk($sformatf("bp%0d_ready", c), req_ready, pat[c] ? 3'b010 : 3'b000);
         if (mem_valid_in && mem_ready_in) nx++;
         if (pat[c]) k++;
      end
      chk("bp_xfer_count", nx, 3);
      cyc(); req_valid = 3'b000; req_last = 3'b000; mem_ready_in = 1'b1; mem_ack_valid = 1'b1; mem_source_id = 2'd0; #1;
      chk("bp_ackrdy", mem_ack_ready, 1'b1);
      cyc(); mem_ack_valid = 1'b0; #1;
      chk("bp_ack", req_ack, 3'b010);
      cyc(); #1;
      chk("bp_release", grant, 3'b000);

      // Reset in the middle of a packet from requester 2.
      cyc(); req_valid = 3'b100; req_data = 24'hC10000; req_last = 3'b000; #1;
      cyc(); #1;
      chk("rs_byte0", mem_data_in, 8'hC1);
      cyc(); req_data = 24'hC20000; #1;
      chk("rs_byte1", mem_data_in, 8'hC2);
      cyc(); req_data = 24'hC30000; rst = 1'b1; #1;
      cyc(); rst = 1'b0; req_valid = 3'b101; req_data = 24'h000000; #1;
      chk("rs_grant", grant, 3'b000);
      chk("rs_busy", busy, 1'b0);
      chk("rs_mvalid", mem_valid_in, 1'b0);
      chk("rs_ack", req_ack, 3'b000);
      chk("rs_src", ack_source_id, 2'd0);
      cyc(); #1;
      chk("rs_rr_ptr0", grant, 3'b001);
      cyc(); rst = 1'b1; req_valid = 3'b000; #1;
      cyc(); rst = 1'b0; #1;
      chk("rs_clean", busy, 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
      cyc(); req_valid = 3'b001; req_data = 24'h000077; req_last = 3'b001; mem_ready_in = 1'b1; #1;
      chk("to_idle", grant, 3'b000);
      cyc(); #1;
      chk("to_byte", mem_data_in, 8'h77);
      for (int w = 1; w <= 16; w++) begin
         cyc(); req_valid = 3'b000; req_last = 3'b000; #1;
         chk($sformatf("to_wait%0d_ack", w), req_ack, 3'b000);
         chk($sformatf("to_wait%0d_flag", w), timeout_err, 1'b0);
         chk($sformatf("to_wait%0d_ackrdy", w), mem_ack_ready, 1'b1);
      end
      cyc(); #1;
      chk("to_flag", timeout_err, 1'b1);
      chk("to_ack", req_ack, 3'b001);
      cyc(); #1;
      chk("to_busy_fall", busy, 1'b0);
      txn(3'b001, 0, 2'd1);
      cyc(); req_valid = 3'b000; req_last = 3'b000; #1;
      chk("to_sticky", timeout_err, 1'b1);
      cyc(); rst = 1'b1; #1;
      cyc(); rst = 1'b0; #1;
      chk("to_cleared", timeout_err, 1'b0);
`else
      chk("timeout_tied", timeout_err, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
